// File: rtl/btn_pkg.sv
// Shared types and default timing constants for the push-button debouncer.
// Defaults assume a 12 MHz system clock.
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE       = 2'd0,
      PRESS_DB   = 2'd1,
      HELD       = 2'd2,
      RELEASE_DB = 2'd3
   } btn_state_t;

   // 10 ms debounce window and 1 s long-press threshold at 12 MHz
   localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 120000;
   localparam int unsigned LONG_CYCLES_DEFAULT     = 12000000;

endpackage

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for bringing asynchronous inputs into the clk domain.
// Both stages clear to 0 on reset so a held button re-debounces after reset.
module sync_2ff #(
   parameter int unsigned WIDTH = 1
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q
);

   logic [WIDTH-1:0] meta_reg;
   logic [WIDTH-1:0] sync_reg;

   for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            meta_reg[gi] <= 1'b0;
            sync_reg[gi] <= 1'b0;
         end else begin
            meta_reg[gi] <= d[gi];
            sync_reg[gi] <= meta_reg[gi];
         end
      end
   end

   assign q = sync_reg;

endmodule

// File: rtl/button_debounce.sv
// Push-button debouncer: level, press/release/long-press strobes and a press counter.
// Every output is a flop; the raw button only reaches logic through sync_2ff.
module button_debounce
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
   parameter int unsigned LONG_CYCLES     = LONG_CYCLES_DEFAULT
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn,
   output logic       btn_level,
   output logic       press_pulse,
   output logic       release_pulse,
   output logic       long_pulse,
   output logic [7:0] press_count
);

   localparam int unsigned DB_W   = $clog2(DEBOUNCE_CYCLES);
   localparam int unsigned HOLD_W = $clog2(LONG_CYCLES);

   localparam logic [DB_W-1:0]   DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(LONG_CYCLES - 1);

   logic btn_s;

   btn_state_t        state_reg,         state_next;
   logic [DB_W-1:0]   db_cnt_reg,        db_cnt_next;
   logic [HOLD_W-1:0] hold_cnt_reg,      hold_cnt_next;
   logic              long_fired_reg,    long_fired_next;
   logic              btn_level_reg,     btn_level_next;
   logic              press_pulse_reg,   press_pulse_next;
   logic              release_pulse_reg, release_pulse_next;
   logic              long_pulse_reg,    long_pulse_next;
   logic [7:0]        press_count_reg,   press_count_next;

   sync_2ff #(
      .WIDTH (1)
   ) u_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d     (btn),
      .q     (btn_s)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg         <= IDLE;
         db_cnt_reg        <= '0;
         hold_cnt_reg      <= '0;
         long_fired_reg    <= 1'b0;
         btn_level_reg     <= 1'b0;
         press_pulse_reg   <= 1'b0;
         release_pulse_reg <= 1'b0;
         long_pulse_reg    <= 1'b0;
         press_count_reg   <= 8'd0;
      end else begin
         state_reg         <= state_next;
         db_cnt_reg        <= db_cnt_next;
         hold_cnt_reg      <= hold_cnt_next;
         long_fired_reg    <= long_fired_next;
         btn_level_reg     <= btn_level_next;
         press_pulse_reg   <= press_pulse_next;
         release_pulse_reg <= release_pulse_next;
         long_pulse_reg    <= long_pulse_next;
         press_count_reg   <= press_count_next;
      end
   end

   always_comb begin
      state_next         = state_reg;
      db_cnt_next        = db_cnt_reg;
      hold_cnt_next      = hold_cnt_reg;
      long_fired_next    = long_fired_reg;
      btn_level_next     = btn_level_reg;
      press_pulse_next   = 1'b0;
      release_pulse_next = 1'b0;
      long_pulse_next    = 1'b0;
      press_count_next   = press_count_reg;

      case (state_reg)
         IDLE: begin
            if (btn_s) begin
               state_next  = PRESS_DB;
               db_cnt_next = '0;
            end
         end

         PRESS_DB: begin
            if (!btn_s) begin
               state_next = IDLE;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next       = HELD;
               press_pulse_next = 1'b1;
               btn_level_next   = 1'b1;
               press_count_next = press_count_reg + 8'd1;
               hold_cnt_next    = '0;
               long_fired_next  = 1'b0;
            end else begin
               db_cnt_next = db_cnt_reg + DB_W'(1);
            end
         end

         HELD: begin
            // Long-press check is independent of btn_s so a release on the
            // threshold edge still produces its long_pulse.
            if (hold_cnt_reg != HOLD_LAST) begin
               hold_cnt_next = hold_cnt_reg + HOLD_W'(1);
            end else if (!long_fired_reg) begin
               long_pulse_next = 1'b1;
               long_fired_next = 1'b1;
            end
            if (!btn_s) begin
               state_next  = RELEASE_DB;
               db_cnt_next = '0;
            end
         end

         RELEASE_DB: begin
            // Hold counter and long-fired flag are left untouched here so a
            // release glitch resumes the same press.
            if (btn_s) begin
               state_next = HELD;
            end else if (db_cnt_reg == DB_LAST) begin
               state_next         = IDLE;
               release_pulse_next = 1'b1;
               btn_level_next     = 1'b0;
            end else begin
               db_cnt_next = db_cnt_reg + DB_W'(1);
            end
         end

         default: begin
            state_next = IDLE;
         end
      endcase
   end

   assign btn_level     = btn_level_reg;
   assign press_pulse   = press_pulse_reg;
   assign release_pulse = release_pulse_reg;
   assign long_pulse    = long_pulse_reg;
   assign press_count   = press_count_reg;

endmodule
